// File: rtl/array_arith_pkg.sv
// array_arith_pkg: shared helpers for the pipelined array divider and multiplier.
package array_arith_pkg;
   localparam int DEF_WIDTH = 8;
   localparam int PROD_WIDTH = 2 * DEF_WIDTH;
   function automatic logic [63:0] stage_mask(input int width, input int n);
      logic [63:0] m;
      m = '0;
      for (int i = 0; i < 64; i++) m[i] = (i < width) && (i < n);
      return m;
   endfunction
endpackage

// File: rtl/mul_stage_comb.sv
// mul_stage_comb: one combinational shift-add row of the array multiplier.
module mul_stage_comb #(
   parameter int WIDTH = 8,
   parameter int BIT_POS = 0
) (
   input  logic [2*WIDTH-1:0] in_acc,
   input  logic [WIDTH-1:0]   A_in,
   input  logic [WIDTH-1:0]   B_in,
   output logic [2*WIDTH-1:0] out_acc
);
   logic [2*WIDTH-1:0] addend;
   always_comb addend = (((B_in >> BIT_POS) & WIDTH'(1)) != '0) ? ((2*WIDTH)'(A_in) << BIT_POS) : '0;
   assign out_acc = in_acc + addend;
endmodule

// File: rtl/pipeline_stage.sv
// pipeline_stage: optional register boundary; a plain wire when ENABLE is 0.
module pipeline_stage #(
   parameter int WIDTH = 1,
   parameter bit ENABLE = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] q_q;
   always_ff @(posedge clk) q_q <= rst ? '0 : d;
   assign q = ENABLE ? q_q : d;
endmodule

// File: rtl/array_mul_reconstruct.sv
// array_mul_reconstruct: pipelined P = A*B + C with NUM_PIPELINE_STAGES enabled boundaries.
module array_mul_reconstruct
   import array_arith_pkg::*;
#(
   parameter int DATAWIDTH = 8,
   parameter int NUM_PIPELINE_STAGES = 1,
   parameter int INSTANCE_ID = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_valid,
   input  logic [DATAWIDTH-1:0]   A,
   input  logic [DATAWIDTH-1:0]   B,
   input  logic [DATAWIDTH-1:0]   C,
   output logic                   o_valid,
   output logic [2*DATAWIDTH-1:0] P_out
);
   localparam int W = DATAWIDTH;
   localparam int PW = 2 * W;
   localparam int SW = PW + 2 * W + 1;
   // INSTANCE_ID only tags the instance for scripts; multiplied by zero here
   localparam logic [63:0] MASK = stage_mask(W + 1, NUM_PIPELINE_STAGES + 0 * INSTANCE_ID);
   // Boundary word layout: {acc, A, B, valid}
   logic [SW-1:0] s_d [W+1];
   logic [SW-1:0] s_q [W+1];
   assign s_d[0] = {{W{1'b0}}, C, A, B, i_valid};
   for (genvar k = 0; k <= W; k++) begin : g_b
      pipeline_stage #(.WIDTH(SW), .ENABLE(MASK[k])) u_ps (
         .clk(clk),
         .rst(rst),
         .d(s_d[k]),
         .q(s_q[k])
      );
      if (k < W) begin : g_row
         logic [PW-1:0] acc;
         mul_stage_comb #(.WIDTH(W), .BIT_POS(k)) u_row (
            .in_acc(s_q[k][SW-1 -: PW]),
            .A_in(s_q[k][2*W:W+1]),
            .B_in(s_q[k][W:1]),
            .out_acc(acc)
         );
         assign s_d[k+1] = {acc, s_q[k][2*W:0]};
      end
   end
   assign P_out = s_q[W][SW-1 -: PW];
   assign o_valid = s_q[W][0];
endmodule

// File: tb/tb_array_mul_reconstruct.sv
// tb_array_mul_reconstruct: scoreboard bench over N = 3, 0, 1, 5, 9 instances sharing one stimulus.
module tb_array_mul_reconstruct;
   localparam int NI = 5;
   function automatic int nsel(input int g);
      return g == 0 ? 3 : g == 1 ? 0 : g == 2 ? 1 : g == 3 ? 5 : 9;
   endfunction
   typedef struct {
      int p;
      int due;
   } exp_t;
   logic clk, rst, i_valid, chk_en;
   logic [7:0] A, B, C;
   logic ov [NI];
   logic [15:0] pw [NI];
   exp_t sbq [NI][$];
   int cyc, n_chk, n_err;
   for (genvar g = 0; g < NI; g++) begin : g_dut
      array_mul_reconstruct #(.DATAWIDTH(8), .NUM_PIPELINE_STAGES(nsel(g)), .INSTANCE_ID(g)) u_dut (
         .clk(clk),
         .rst(rst),
         .i_valid(i_valid),
         .A(A),
         .B(B),
         .C(C),
         .o_valid(ov[g]),
         .P_out(pw[g])
      );
   end
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask
   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < NI; i++) begin
            bit ev;
            ev = sbq[i].size() > 0 && sbq[i][0].due == cyc;
            chk($sformatf("o_valid[N=%0d]", nsel(i)), int'(ov[i]), int'(ev));
            if (ev) begin
               if (ov[i]) chk($sformatf("P_out[N=%0d]", nsel(i)), int'(pw[i]), sbq[i][0].p);
               void'(sbq[i].pop_front());
            end
         end
      end
   end
   task automatic drive(input int a, input int b, input int c, input bit v, input int exp);
      @(posedge clk);
      #1;
      A = 8'(a);
      B = 8'(b);
      C = 8'(c);
      i_valid = v;
      if (v) for (int i = 0; i < NI; i++) sbq[i].push_back('{exp, cyc + nsel(i)});
   endtask
   task automatic idle(input int n);
      for (int j = 0; j < n; j++) drive(0, 0, 0, 1'b0, 0);
   endtask
   initial begin
      cyc = 0;
      n_chk = 0;
      n_err = 0;
      chk_en = 1'b0;
      rst = 1'b1;
      i_valid = 1'b0;
      A = '0;
      B = '0;
      C = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("rst_ov[N=%0d]", nsel(i)), int'(ov[i]), 0);
         chk($sformatf("rst_p[N=%0d]", nsel(i)), int'(pw[i]), 0);
      end
      chk_en = 1'b1;
      drive(13, 11, 5, 1'b1, 148);
      idle(12);
      drive(255, 255, 255, 1'b1, 65280);
      drive(0, 77, 9, 1'b1, 9);
      drive(77, 0, 0, 1'b1, 0);
      idle(12);
      drive(28, 7, 4, 1'b1, 200);
      drive(1, 255, 0, 1'b1, 255);
      drive(0, 9, 5, 1'b1, 5);
      drive(85, 3, 0, 1'b1, 255);
      idle(12);
      // mid-flight reset: two vectors, then rst for one edge
      drive(200, 100, 50, 1'b1, 20050);
      @(negedge clk) chk("mid_p0", int'(pw[0]), 0);
      drive(17, 19, 3, 1'b1, 326);
      @(negedge clk) chk("mid_p1", int'(pw[0]), 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      i_valid = 1'b0;
      A = '0;
      B = '0;
      C = '0;
      @(negedge clk) chk("mid_p2", int'(pw[0]), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < NI; i++) if (nsel(i) > 0) sbq[i].delete();
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         chk("post_rst_p", int'(pw[0]), 0);
         chk("post_rst_ov", int'(ov[0]), 0);
      end
      drive(21, 12, 7, 1'b1, 259);
      idle(12);
      for (int n = 0; n < 1000; n++) begin
         int a, b, c, gap;
         gap = $urandom_range(0, 2);
         for (int j = 0; j < gap; j++) drive($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), 1'b0, 0);
         a = $urandom_range(0, 255);
         b = $urandom_range(0, 255);
         c = $urandom_range(0, 255);
         drive(a, b, c, 1'b1, a * b + c);
      end
      idle(14);
      @(negedge clk);
      for (int i = 0; i < NI; i++) chk($sformatf("drain[N=%0d]", nsel(i)), sbq[i].size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
